// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data (LOAD/STOR) requesters.
// Optional round-robin arbitration on collisions: define MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_data_q, sel_data_d;
    logic                we_q, we_d;
    logic                if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic                busy_q, busy_d;
    logic                accept, latch, pick_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_data_q, last_data_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_data_q  <= 1'b0;
            we_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_data_q  <= sel_data_d;
            we_q        <= we_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // Next state and next output values; every edge that lands in IDLE also samples requests
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_data_d  = sel_data_q;
        we_d        = we_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        accept      = 1'b0;
        latch       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
        pick_data   = d_req && (!if_req || !last_data_q);
`else
        pick_data   = d_req;
`endif

        case (state_q)
            S_IDLE: accept = 1'b1;
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                    accept  = 1'b1;
                end else if (READ_LATENCY <= 1) begin
                    state_d = S_RESP;
                    latch   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    latch   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                accept  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Read data lands on the edge it is valid at the memory port
        if (latch) begin
            if (sel_data_q) begin
                d_rdata_d  = mem_rdata;
                d_rvalid_d = 1'b1;
            end else begin
                if_rdata_d  = mem_rdata;
                if_rvalid_d = 1'b1;
            end
        end

        if (accept && (if_req || d_req)) begin
            state_d    = S_ISSUE;
            sel_data_d = pick_data;
            we_d       = pick_data && d_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data_d = pick_data;
`endif
            if (pick_data) begin
                d_gnt_d    = 1'b1;
                mem_addr_d = d_addr;
                if (d_we) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = d_wdata;
                end else begin
                    mem_re_d = 1'b1;
                end
            end else begin
                if_gnt_d   = 1'b1;
                mem_addr_d = if_addr;
                mem_re_d   = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at read latencies 1, 3 and 4 share stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] mem_val = '0;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_we1, mem_re1, busy1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_we3, mem_re3, busy3;
    logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, mem_we4, mem_re4, busy4;
    logic [15:0] if_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;

    logic [3:0]  v3 = '0;
    logic [3:0]  v4 = '0;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: data is valid in the cycle just before the sampling edge READ_LATENCY edges after mem_re
    always @(posedge clk) begin
        v3 <= {v3[2:0], mem_re3};
        v4 <= {v4[2:0], mem_re4};
    end
    assign mem_rdata1 = mem_re1 ? mem_val : 16'hDEAD;
    assign mem_rdata3 = v3[1]   ? mem_val : 16'hDEAD;
    assign mem_rdata4 = v4[2]   ? mem_val : 16'hDEAD;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(3)) u3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_re(mem_re3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(4)) u4 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt4), .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_we(mem_we4), .mem_re(mem_re4),
        .mem_rdata(mem_rdata4), .busy(busy4)
    );

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] mem_val;
    } vin_t;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [15:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [15:0] d_rdata;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        mem_we;
        logic        mem_re;
        logic        busy;
    } vout_t;

    typedef struct {
        vin_t  in;
        vout_t exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic vin_t mi(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                                input logic [15:0] da, input logic [15:0] dd, input logic [15:0] mv);
        vin_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.mem_val = mv;
        return v;
    endfunction

    function automatic vout_t mo(input logic ig, input logic iv, input logic [15:0] ird,
                                 input logic dg, input logic dv, input logic [15:0] drd,
                                 input logic [15:0] ma, input logic [15:0] mw,
                                 input logic we, input logic re, input logic bz);
        vout_t o;
        o.if_gnt = ig; o.if_rvalid = iv; o.if_rdata = ird;
        o.d_gnt = dg; o.d_rvalid = dv; o.d_rdata = drd;
        o.mem_addr = ma; o.mem_wdata = mw; o.mem_we = we; o.mem_re = re; o.busy = bz;
        return o;
    endfunction

    function automatic vout_t cap1();
        vout_t o;
        o.if_gnt = if_gnt1; o.if_rvalid = if_rvalid1; o.if_rdata = if_rdata1;
        o.d_gnt = d_gnt1; o.d_rvalid = d_rvalid1; o.d_rdata = d_rdata1;
        o.mem_addr = mem_addr1; o.mem_wdata = mem_wdata1; o.mem_we = mem_we1;
        o.mem_re = mem_re1; o.busy = busy1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vin_t v);
        if_req  = v.if_req;
        if_addr = v.if_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        mem_val = v.mem_val;
    endtask

    task automatic do_reset();
        drive(mi(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0));
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         k;
        int         n;
        logic       seen;
        logic [3:0] order;
        logic [3:0] exp_order;

        // Cycle-by-cycle vectors for the READ_LATENCY=1 instance; expectation is the state after each edge
        vecs[0]  = '{in: mi(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000),
                     exp: mo(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0)};
        vecs[1]  = '{in: mi(0, 16'h0000, 1, 1, 16'h00F0, 16'hBEEF, 16'h0000),
                     exp: mo(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h00F0, 16'hBEEF, 1, 0, 1)};
        vecs[2]  = '{in: mi(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000),
                     exp: mo(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0)};
        vecs[3]  = '{in: mi(1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 16'h5123),
                     exp: mo(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004, 16'h0000, 0, 1, 1)};
        vecs[4]  = '{in: mi(0, 16'h0004, 0, 0, 16'h0000, 16'h0000, 16'h5123),
                     exp: mo(0, 1, 16'h5123, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1)};
        vecs[5]  = '{in: mi(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000),
                     exp: mo(0, 0, 16'h5123, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0)};
        vecs[6]  = '{in: mi(1, 16'h0008, 1, 0, 16'h0100, 16'h0000, 16'h7777),
                     exp: mo(0, 0, 16'h5123, 1, 0, 16'h0000, 16'h0100, 16'h0000, 0, 1, 1)};
        vecs[7]  = '{in: mi(1, 16'h0008, 1, 0, 16'h0100, 16'h0000, 16'h7777),
                     exp: mo(0, 0, 16'h5123, 0, 1, 16'h7777, 16'h0000, 16'h0000, 0, 0, 1)};
        vecs[8]  = '{in: mi(1, 16'h0008, 0, 0, 16'h0000, 16'h0000, 16'h1234),
                     exp: mo(1, 0, 16'h5123, 0, 0, 16'h7777, 16'h0008, 16'h0000, 0, 1, 1)};
        vecs[9]  = '{in: mi(0, 16'h0008, 0, 0, 16'h0000, 16'h0000, 16'h1234),
                     exp: mo(0, 1, 16'h1234, 0, 0, 16'h7777, 16'h0000, 16'h0000, 0, 0, 1)};
        vecs[10] = '{in: mi(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000),
                     exp: mo(0, 0, 16'h1234, 0, 0, 16'h7777, 16'h0000, 16'h0000, 0, 0, 0)};

        // Outputs are all zero while reset is held
        reset = 1'b0;
        #2;
        chk("reset_outputs", 128'(cap1()), 128'(vout_t'('0)));

        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].in);
            step();
            chk($sformatf("vec%0d", i), 128'(cap1()), 128'(vecs[i].exp));
        end

        // Reset asserted while the latency-3 instance waits on a fetch read
        do_reset();
        drive(mi(1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'hCAFE));
        step();
        chk("rst_mid_gnt", {if_gnt3, mem_re3, mem_addr3}, {1'b1, 1'b1, 16'h0010});
        if_req = 1'b0;
        step();
        chk("rst_mid_wait", {busy3, mem_re3, if_gnt3}, {1'b1, 1'b0, 1'b0});
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_zero", {if_gnt3, if_rvalid3, if_rdata3, d_gnt3, d_rvalid3, d_rdata3,
                             mem_addr3, mem_wdata3, mem_we3, mem_re3, busy3}, 128'(0));
        #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if_rvalid3) seen = 1'b1;
        end
        chk("rst_mid_no_rvalid", 128'(seen), 128'(0));
        chk("rst_mid_busy", 128'(busy3), 128'(0));

        // Latency-4 data read: rvalid READ_LATENCY cycles after the grant cycle
        do_reset();
        drive(mi(0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 16'h00A5));
        step();
        chk("lat4_gnt", {d_gnt4, mem_re4, mem_addr4}, {1'b1, 1'b1, 16'h0200});
        d_req = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (d_rvalid4) begin
                k = i;
                break;
            end
        end
        chk("lat4_delay", 128'(k), 128'(4));
        chk("lat4_rdata", 128'(d_rdata4), 128'(16'h00A5));
        step();
        chk("lat4_rvalid_pulse", {d_rvalid4, busy4}, {1'b0, 1'b0});

        // Both requesters held for four grants
        do_reset();
        drive(mi(1, 16'h0400, 1, 0, 16'h0300, 16'h0000, 16'h4444));
        n = 0;
        order = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            step();
            if (d_gnt1 || if_gnt1) begin
                order[3 - n] = d_gnt1;
                chk($sformatf("hold_addr%0d", n), 128'(mem_addr1), d_gnt1 ? 128'(16'h0300) : 128'(16'h0400));
                n++;
            end
        end
        drive(mi(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000));
        chk("hold_grants", 128'(n), 128'(4));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1111;
`endif
        chk("hold_order", 128'(order), 128'(exp_order));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
